sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Two-master arbiter placed between the packet-processing switch and the shared SRAM.
- Master 0 is the switch datapath; master 1 is the reconfiguration/table loader.
- Grants at most one SRAM access per cycle using round-robin priority, drives a registered SRAM command port, and routes read data back to the issuing master.
- Keeps saturating per-master grant counters for performance monitoring.

Parameters:
- ADDR_W, 32, address width; matches `ADDR_BUS in def.svh.
- DATA_W, 32, data width; matches `DATA_BUS.
- SEL_W, 4, byte-lane select width, equal to DATA_W/8.
- CNT_W, 16, width of each grant counter.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- m_req_i  in  2  per-master access request, index 0 = switch, index 1 = loader.
- m_we_i  in  2  per-master write enable; 1 = write, 0 = read.
- m_addr_i  in  2*ADDR_W  per-master address.
- m_sel_i  in  2*SEL_W  per-master byte-lane select.
- m_wdata_i  in  2*DATA_W  per-master write data.
- m_gnt_o  out  2  combinational grant; the request is accepted in the cycle this is high.
- m_rvalid_o  out  2  registered one-cycle read-data valid, per master.
- m_rdata_o  out  DATA_W  read data; meaningful only when m_rvalid_o is high.
- sram_ce_o  out  1  registered SRAM chip enable.
- sram_we_o  out  1  registered SRAM write enable.
- sram_addr_o  out  ADDR_W  registered SRAM address.
- sram_sel_o  out  SEL_W  registered SRAM byte-lane select.
- sram_data_o  out  DATA_W  registered SRAM write data.
- sram_data_i  in  DATA_W  SRAM read data, valid the cycle after a read command.
- gnt_cnt0_o  out  CNT_W  saturating count of master-0 grants.
- gnt_cnt1_o  out  CNT_W  saturating count of master-1 grants.

Behaviour:
- Reset (rst=0, asynchronous):
  - All sram_* outputs are 0, m_rvalid_o=0, both counters 0, round-robin pointer rr=0 (master 0 preferred).
  - m_gnt_o is forced 0 while reset is asserted.
- Arbitration (combinational, cycle T):
  - Exactly one request: that master is granted.
  - Both request: master rr is granted.
  - No request: no grant.
  - m_gnt_o is one-hot or zero, never both bits set.
- Pointer update at the end of T, only if a grant occurred: rr <= ~granted_index. Idle cycles leave rr unchanged.
- Issue: the granted request is registered onto sram_* with sram_ce_o=1 in cycle T+1.
  - In cycles with no grant: sram_ce_o=0, sram_we_o=0; addr/sel/data hold their previous values.
- Read return:
  - The SRAM presents data in T+2.
  - The tag pipeline (valid and master index) is two stages deep. In T+2, m_rvalid_o[tag] is 1 and m_rdata_o = sram_data_i (combinational pass-through).
  - Writes never produce m_rvalid_o.
- Throughput is one access per cycle, with reads and writes freely interleaved. Back-to-back reads from different masters return in issue order, each with the correct tag.
- Read-after-write to the same address in consecutive grants returns the new data, because the SRAM sees the write first.
- Masters hold req and all fields stable until granted; the arbiter does not check this.
- Counters:
  - gnt_cntN_o increments by 1 on each grant to master N.
  - At 2^CNT_W-1 it holds (saturates, no wrap).
  - Counters clear only on reset.
- Reset mid-operation: in-flight commands and reads are discarded. No m_rvalid_o is produced for them after reset is released.
- Requests with m_sel_i=0 are still granted and issued unchanged.

Decomposition:
- Shared package/def.svh:
  - `ADDR_BUS and `DATA_BUS.
  - Master index constants MST_SWITCH=0 and MST_LOADER=1.
  - A typedef for the request bundle (we, addr, sel, wdata).
- One sub-module, rr_arbiter2: combinational two-way grant plus registered rr pointer. Reusable for future ports.
- Tag pipeline, SRAM command register and counters stay in sram_arbiter.

Test Plan:
- Reset then a single master-0 read of addr 0x10, after preloading SRAM[0x10]=0xDEADBEEF via a master-1 write of sel 4'hF
  -> m_gnt_o=2'b10 for the write, then 2'b01 for the read; m_rvalid_o=2'b01 two cycles after the read grant with m_rdata_o=0xDEADBEEF.
- Both masters request reads continuously for 6 cycles
  -> grants alternate 0,1,0,1,0,1 starting with master 0; each rvalid tag matches the granting master; gnt_cnt0_o=3, gnt_cnt1_o=3.
- Master 1 writes 0x11223344 to 0x20 with sel 4'b0011, then master 0 reads 0x20 in the next cycle (SRAM[0x20] previously 0xAAAAAAAA)
  -> master 0 receives 0xAAAA3344.
- Master-0 read in flight, rst pulsed low for one cycle between T+1 and T+2
  -> no m_rvalid_o afterwards; sram_ce_o=0; counters=0; the next simultaneous request is granted to master 0.
- CNT_W=4, 20 consecutive master-0 grants -> gnt_cnt0_o saturates at 15 and stays there.
- Idle cycles between alternating grants -> rr does not change while idle; after granting master 1 then idling 3 cycles, a simultaneous request is granted to master 0.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the switch/loader SRAM arbiter: bus widths,
// master indices and the per-master request bundle.
package sram_arbiter_pkg;

  localparam int ADDR_BUS = 32;
  localparam int DATA_BUS = 32;
  localparam int SEL_BUS  = DATA_BUS / 8;

  localparam logic MST_SWITCH = 1'b0;
  localparam logic MST_LOADER = 1'b1;

  typedef struct packed {
    logic                we;
    logic [ADDR_BUS-1:0] addr;
    logic [SEL_BUS-1:0]  sel;
    logic [DATA_BUS-1:0] wdata;
  } mreq_t;

endpackage

// File: rtl/sram_arbiter_rr.sv
// Two-way round-robin grant with a registered preference pointer.
// The pointer flips to the loser of each granted cycle; idle cycles keep it.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o,
  output logic       gnt_vld_o
);

  logic rr_q, rr_d;

  always_comb begin
    gnt_o     = 2'b00;
    gnt_idx_o = 1'b0;
    case (req_i)
      2'b01: gnt_o = 2'b01;
      2'b10: begin
        gnt_o     = 2'b10;
        gnt_idx_o = 1'b1;
      end
      2'b11: begin
        gnt_idx_o = rr_q;
        gnt_o     = rr_q ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
    gnt_vld_o = |req_i;
    rr_d      = gnt_vld_o ? ~gnt_idx_o : rr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= 1'b0;
    else         rr_q <= rr_d;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master SRAM arbiter: round-robin grant, registered SRAM command port,
// two-stage read tag pipeline and saturating per-master grant counters.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_BUS,
  parameter int DATA_W = DATA_BUS,
  parameter int SEL_W  = DATA_W / 8,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          m_req_i,
  input  logic [1:0]          m_we_i,
  input  logic [2*ADDR_W-1:0] m_addr_i,
  input  logic [2*SEL_W-1:0]  m_sel_i,
  input  logic [2*DATA_W-1:0] m_wdata_i,
  output logic [1:0]          m_gnt_o,
  output logic [1:0]          m_rvalid_o,
  output logic [DATA_W-1:0]   m_rdata_o,
  output logic                sram_ce_o,
  output logic                sram_we_o,
  output logic [ADDR_W-1:0]   sram_addr_o,
  output logic [SEL_W-1:0]    sram_sel_o,
  output logic [DATA_W-1:0]   sram_data_o,
  input  logic [DATA_W-1:0]   sram_data_i,
  output logic [CNT_W-1:0]    gnt_cnt0_o,
  output logic [CNT_W-1:0]    gnt_cnt1_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0] arb_gnt;
  logic       gnt_idx;
  logic       gnt_vld;

  rr_arbiter2 u_rr (
    .clk_i     (clk),
    .rst_ni    (rst),
    .req_i     (m_req_i),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  assign m_gnt_o = rst ? arb_gnt : 2'b00;

  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [SEL_W-1:0]  req_sel;
  logic [DATA_W-1:0] req_wdata;

  always_comb begin
    if (gnt_idx == MST_LOADER) begin
      req_we    = m_we_i[1];
      req_addr  = m_addr_i[2*ADDR_W-1:ADDR_W];
      req_sel   = m_sel_i[2*SEL_W-1:SEL_W];
      req_wdata = m_wdata_i[2*DATA_W-1:DATA_W];
    end else begin
      req_we    = m_we_i[0];
      req_addr  = m_addr_i[ADDR_W-1:0];
      req_sel   = m_sel_i[SEL_W-1:0];
      req_wdata = m_wdata_i[DATA_W-1:0];
    end
  end

  // Stage p1: SRAM command register; address/sel/data hold when idle.
  logic              ce_q, ce_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rd_vld_p1_q, rd_vld_p1_d, rd_tag_p1_q;
  logic              rd_vld_p2_q, rd_tag_p2_q;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    ce_d        = gnt_vld;
    we_d        = gnt_vld & req_we;
    addr_d      = gnt_vld ? req_addr  : addr_q;
    sel_d       = gnt_vld ? req_sel   : sel_q;
    data_d      = gnt_vld ? req_wdata : data_q;
    rd_vld_p1_d = gnt_vld & ~req_we;
    cnt0_d      = (arb_gnt[0] && cnt0_q != CNT_MAX) ? cnt0_q + 1'b1 : cnt0_q;
    cnt1_d      = (arb_gnt[1] && cnt1_q != CNT_MAX) ? cnt1_q + 1'b1 : cnt1_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      sel_q       <= '0;
      data_q      <= '0;
      rd_vld_p1_q <= 1'b0;
      rd_tag_p1_q <= 1'b0;
      rd_vld_p2_q <= 1'b0;
      rd_tag_p2_q <= 1'b0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      ce_q        <= ce_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
      rd_vld_p1_q <= rd_vld_p1_d;
      rd_tag_p1_q <= gnt_idx;
      // Stage p2: tag aligned with the SRAM's read data.
      rd_vld_p2_q <= rd_vld_p1_q;
      rd_tag_p2_q <= rd_tag_p1_q;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  always_comb begin
    m_rvalid_o = 2'b00;
    if (rd_vld_p2_q) m_rvalid_o[rd_tag_p2_q] = 1'b1;
  end

  assign m_rdata_o   = sram_data_i;
  assign sram_ce_o   = ce_q;
  assign sram_we_o   = we_q;
  assign sram_addr_o = addr_q;
  assign sram_sel_o  = sel_q;
  assign sram_data_o = data_q;
  assign gnt_cnt0_o  = cnt0_q;
  assign gnt_cnt1_o  = cnt1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM, transaction-level reference model,
// directed scenarios followed by randomized two-master traffic.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  m_req_i, m_we_i;
  logic [63:0] m_addr_i, m_wdata_i;
  logic [7:0]  m_sel_i;
  logic [1:0]  m_gnt_o, m_rvalid_o;
  logic [31:0] m_rdata_o;
  logic        sram_ce_o, sram_we_o;
  logic [31:0] sram_addr_o, sram_data_o;
  logic [3:0]  sram_sel_o;
  logic [31:0] sram_data_i = '0;
  logic [3:0]  gnt_cnt0_o, gnt_cnt1_o;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .SEL_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i),
    .m_sel_i(m_sel_i), .m_wdata_i(m_wdata_i),
    .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
    .sram_ce_o(sram_ce_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_sel_o(sram_sel_o), .sram_data_o(sram_data_o), .sram_data_i(sram_data_i),
    .gnt_cnt0_o(gnt_cnt0_o), .gnt_cnt1_o(gnt_cnt1_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Behavioural SRAM: one-cycle read latency, byte-lane writes.
  logic [31:0] mem [0:255] = '{default: '0};
  always @(posedge clk) begin
    if (sram_ce_o) begin
      if (sram_we_o) mem[sram_addr_o[7:0]] <= merge(mem[sram_addr_o[7:0]], sram_data_o, sram_sel_o);
      else           sram_data_i <= mem[sram_addr_o[7:0]];
    end
  end

  // Reference model: grant order, memory contents and outstanding reads.
  typedef struct { int due; int tag; logic [31:0] data; } ret_t;
  ret_t        rq[$];
  logic [31:0] ref_mem [0:255] = '{default: '0};
  int          last_gnt, cyc;
  int          cnt_m[2];
  logic        nxt_ce, nxt_we;
  logic [31:0] nxt_addr, nxt_data;
  logic [3:0]  nxt_sel;
  logic [1:0]  exp_gnt, exp_rvalid;
  logic [31:0] exp_rdata, exp_addr, exp_data;
  logic        exp_ce, exp_we;
  logic [3:0]  exp_sel, exp_cnt0, exp_cnt1;
  int          n_tests, n_fail;

  task automatic reset_model();
    last_gnt = 1;
    cnt_m[0] = 0; cnt_m[1] = 0;
    rq.delete();
    nxt_ce = 0; nxt_we = 0; nxt_addr = 0; nxt_sel = 0; nxt_data = 0;
  endtask

  task automatic model_step();
    int w;
    logic [31:0] a;
    exp_cnt0 = 4'(cnt_m[0]); exp_cnt1 = 4'(cnt_m[1]);
    exp_ce = nxt_ce; exp_we = nxt_we; exp_addr = nxt_addr; exp_sel = nxt_sel; exp_data = nxt_data;
    exp_rvalid = 2'b00; exp_rdata = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      exp_rvalid[rq[0].tag] = 1'b1;
      exp_rdata = rq[0].data;
      void'(rq.pop_front());
    end
    w = -1;
    if (m_req_i == 2'b11) w = 1 - last_gnt;
    else if (m_req_i[0])  w = 0;
    else if (m_req_i[1])  w = 1;
    exp_gnt = 2'b00; nxt_ce = 0; nxt_we = 0;
    if (w >= 0) begin
      exp_gnt[w] = 1'b1;
      last_gnt = w;
      if (cnt_m[w] < 15) cnt_m[w]++;
      a = m_addr_i[w*32 +: 32];
      nxt_ce = 1; nxt_we = m_we_i[w]; nxt_addr = a;
      nxt_sel = m_sel_i[w*4 +: 4]; nxt_data = m_wdata_i[w*32 +: 32];
      if (m_we_i[w]) ref_mem[a[7:0]] = merge(ref_mem[a[7:0]], nxt_data, nxt_sel);
      else rq.push_back('{cyc + 2, w, ref_mem[a[7:0]]});
    end
    cyc++;
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] we,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [3:0] s0, input logic [3:0] s1,
                       input logic [31:0] w0, input logic [31:0] w1);
    m_req_i = req; m_we_i = we; m_addr_i = {a1, a0};
    m_sel_i = {s1, s0}; m_wdata_i = {w1, w0};
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    reset_model();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(2'b11, 2'b00, 32'h4, 32'h8, 4'hF, 4'hF, 0, 0);
    @(negedge clk); #1;
    n_tests++; if (m_gnt_o !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got %b exp 00", m_gnt_o); end
    n_tests++; if (sram_ce_o !== 1'b0 || sram_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_ce got ce=%b we=%b exp 0", sram_ce_o, sram_we_o); end
    n_tests++; if (sram_addr_o !== 0 || sram_data_o !== 0 || sram_sel_o !== 0) begin n_fail++; $display("FAIL reset_cmd got %h/%h/%h exp 0", sram_addr_o, sram_sel_o, sram_data_o); end
    n_tests++; if (m_rvalid_o !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got %b exp 00", m_rvalid_o); end
    n_tests++; if (gnt_cnt0_o !== 0 || gnt_cnt1_o !== 0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", gnt_cnt0_o, gnt_cnt1_o); end
    @(negedge clk);
    rst = 1'b1;
    drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    reset_model();
  endtask

  task automatic test_single_rw();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      drive(2'b10, 2'b10, 0, 32'h10, 0, 4'hF, 0, 32'hDEADBEEF);
      else if (i == 1) drive(2'b01, 2'b00, 32'h10, 0, 4'hF, 0, 0, 0);
      else             drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
      #1; model_step();
      n_tests++; if (m_gnt_o !== exp_gnt) begin n_fail++; $display("FAIL single_gnt c%0d got %b exp %b", i, m_gnt_o, exp_gnt); end
      n_tests++; if (m_rvalid_o !== exp_rvalid) begin n_fail++; $display("FAIL single_rvalid c%0d got %b exp %b", i, m_rvalid_o, exp_rvalid); end
      if (i == 3) begin
        n_tests++; if (m_rvalid_o !== 2'b01 || m_rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rdata got %b/%h exp 01/deadbeef", m_rvalid_o, m_rdata_o); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_alternate();
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      if (i < 6) drive(2'b11, 2'b00, 32'(i), 32'(16 + i), 4'hF, 4'hF, 0, 0);
      else       drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
      #1; model_step();
      if (i < 6) begin
        n_tests++; if (m_gnt_o !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL alt_gnt c%0d got %b", i, m_gnt_o); end
      end
      n_tests++; if (m_rvalid_o !== exp_rvalid || (exp_rvalid != 0 && m_rdata_o !== exp_rdata)) begin
        n_fail++; $display("FAIL alt_ret c%0d got %b/%h exp %b/%h", i, m_rvalid_o, m_rdata_o, exp_rvalid, exp_rdata); end
      @(negedge clk);
    end
    n_tests++; if (gnt_cnt0_o !== 4'd3 || gnt_cnt1_o !== 4'd3) begin n_fail++; $display("FAIL alt_cnt got %0d/%0d exp 3/3", gnt_cnt0_o, gnt_cnt1_o); end
  endtask

  task automatic test_raw();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      drive(2'b10, 2'b10, 0, 32'h20, 0, 4'hF, 0, 32'hAAAAAAAA);
      else if (i == 1) drive(2'b10, 2'b10, 0, 32'h20, 0, 4'b0011, 0, 32'h11223344);
      else if (i == 2) drive(2'b01, 2'b00, 32'h20, 0, 4'hF, 0, 0, 0);
      else             drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
      #1; model_step();
      n_tests++; if (m_gnt_o !== exp_gnt) begin n_fail++; $display("FAIL raw_gnt c%0d got %b exp %b", i, m_gnt_o, exp_gnt); end
      if (i == 4) begin
        n_tests++; if (m_rvalid_o !== 2'b01 || m_rdata_o !== 32'hAAAA3344) begin n_fail++; $display("FAIL raw_rdata got %b/%h exp 01/aaaa3344", m_rvalid_o, m_rdata_o); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    drive(2'b01, 2'b00, 32'h10, 0, 4'hF, 0, 0, 0);
    #1; model_step();
    n_tests++; if (m_gnt_o !== 2'b01) begin n_fail++; $display("FAIL mid_gnt got %b exp 01", m_gnt_o); end
    @(negedge clk);
    drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    #1;
    n_tests++; if (sram_ce_o !== 1'b1) begin n_fail++; $display("FAIL mid_issue got ce=%b exp 1", sram_ce_o); end
    rst = 1'b0; #1;
    n_tests++; if (sram_ce_o !== 1'b0 || gnt_cnt0_o !== 0 || gnt_cnt1_o !== 0) begin
      n_fail++; $display("FAIL mid_clear got ce=%b cnt=%0d/%0d exp 0", sram_ce_o, gnt_cnt0_o, gnt_cnt1_o); end
    @(negedge clk);
    rst = 1'b1;
    reset_model();
    for (int i = 0; i < 4; i++) begin
      #1; model_step();
      n_tests++; if (m_rvalid_o !== 2'b00) begin n_fail++; $display("FAIL mid_rvalid c%0d got %b exp 00", i, m_rvalid_o); end
      @(negedge clk);
    end
    drive(2'b11, 2'b00, 32'h1, 32'h2, 4'hF, 4'hF, 0, 0);
    #1; model_step();
    n_tests++; if (m_gnt_o !== 2'b01) begin n_fail++; $display("FAIL mid_after got %b exp 01", m_gnt_o); end
    @(negedge clk);
    drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    repeat (3) begin #1; model_step(); @(negedge clk); end
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      drive(2'b01, 2'b10, 32'(i), 0, 4'hF, 0, 0, 0);
      #1; model_step();
      n_tests++; if (gnt_cnt0_o !== exp_cnt0) begin n_fail++; $display("FAIL sat_cnt c%0d got %0d exp %0d", i, gnt_cnt0_o, exp_cnt0); end
      @(negedge clk);
    end
    drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    repeat (3) begin #1; model_step(); @(negedge clk); end
    n_tests++; if (gnt_cnt0_o !== 4'd15 || gnt_cnt1_o !== 4'd0) begin n_fail++; $display("FAIL sat_final got %0d/%0d exp 15/0", gnt_cnt0_o, gnt_cnt1_o); end
  endtask

  task automatic test_idle_rr();
    logic [1:0] want [0:2];
    want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01;
    apply_reset();
    for (int g = 0; g < 3; g++) begin
      drive(2'b11, 2'b11, 32'h30, 32'h31, 4'hF, 4'hF, 32'(g), 32'(g));
      #1; model_step();
      n_tests++; if (m_gnt_o !== want[g]) begin n_fail++; $display("FAIL idle_rr g%0d got %b exp %b", g, m_gnt_o, want[g]); end
      @(negedge clk);
      drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
      repeat (3) begin #1; model_step(); @(negedge clk); end
    end
  endtask

  task automatic test_random();
    logic        pend [2];
    logic        rwe  [2];
    logic [31:0] radr [2], rwd [2];
    logic [3:0]  rsel [2];
    apply_reset();
    for (int m = 0; m < 2; m++) begin pend[m] = 0; rwe[m] = 0; radr[m] = 0; rwd[m] = 0; rsel[m] = 0; end
    for (int i = 0; i < 303; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && i < 300 && $urandom_range(0, 99) < 60) begin
          pend[m] = 1; rwe[m] = 1'($urandom_range(0, 1)); radr[m] = 32'($urandom_range(0, 15));
          rsel[m] = 4'($urandom_range(0, 15)); rwd[m] = $urandom;
        end
      end
      drive({pend[1], pend[0]}, {rwe[1], rwe[0]}, radr[0], radr[1], rsel[0], rsel[1], rwd[0], rwd[1]);
      #1; model_step();
      n_tests++; if (m_gnt_o !== exp_gnt) begin n_fail++; $display("FAIL rnd_gnt c%0d got %b exp %b", i, m_gnt_o, exp_gnt); end
      n_tests++; if (m_rvalid_o !== exp_rvalid || (exp_rvalid != 0 && m_rdata_o !== exp_rdata)) begin
        n_fail++; $display("FAIL rnd_ret c%0d got %b/%h exp %b/%h", i, m_rvalid_o, m_rdata_o, exp_rvalid, exp_rdata); end
      n_tests++; if (sram_ce_o !== exp_ce || sram_we_o !== exp_we || sram_addr_o !== exp_addr ||
                     sram_sel_o !== exp_sel || sram_data_o !== exp_data) begin
        n_fail++; $display("FAIL rnd_cmd c%0d got %b%b %h %h %h exp %b%b %h %h %h", i, sram_ce_o, sram_we_o,
                           sram_addr_o, sram_sel_o, sram_data_o, exp_ce, exp_we, exp_addr, exp_sel, exp_data); end
      n_tests++; if (gnt_cnt0_o !== exp_cnt0 || gnt_cnt1_o !== exp_cnt1) begin
        n_fail++; $display("FAIL rnd_cnt c%0d got %0d/%0d exp %0d/%0d", i, gnt_cnt0_o, gnt_cnt1_o, exp_cnt0, exp_cnt1); end
      for (int m = 0; m < 2; m++) if (exp_gnt[m]) pend[m] = 0;
      @(negedge clk);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    rst = 1'b0;
    drive(2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    reset_model();
    @(negedge clk);
    test_reset();
    test_single_rw();
    test_alternate();
    test_raw();
    test_reset_midflight();
    test_saturate();
    test_idle_rr();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
